// File: rtl/blink_code.sv
// Plays a status code on one LED as N on/off pulses followed by a gap, paced by an external tick.
// Optional BLINK_CODE_DIM_EN adds a duty_i port that PWM-dims the LED during the ON phase.
module blink_code #(
   parameter int unsigned CODE_W    = 4,
   parameter int unsigned ON_TICKS  = 2,
   parameter int unsigned OFF_TICKS = 2,
   parameter int unsigned GAP_TICKS = 6
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              tick_i,
   input  logic [CODE_W-1:0] code_i,
   input  logic              code_valid_i,
   output logic              code_ready_o,
   input  logic              repeat_i,
   input  logic              stop_i,
`ifdef BLINK_CODE_DIM_EN
   input  logic [3:0]        duty_i,
`endif
   output logic              led_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int unsigned MAX_OO = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int unsigned MAX_T  = (MAX_OO > GAP_TICKS) ? MAX_OO : GAP_TICKS;
   localparam int unsigned CNT_W  = $clog2(MAX_T + 1);

   if (CODE_W == 0 || ON_TICKS == 0 || OFF_TICKS == 0 || GAP_TICKS == 0) begin : g_bad_param
      $error("blink_code: all parameters must be non-zero");
   end

   typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CODE_W-1:0]   pulses_q, pulses_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic                led_q, led_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                accept;
`ifdef BLINK_CODE_DIM_EN
   logic [3:0]          dim_q, dim_d;
`endif

   assign code_ready_o = (state_q == S_IDLE) & ~stop_i;
   assign accept       = code_valid_i & code_ready_o;

   // Next-state, phase counting and registered-output decode
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pulses_d = pulses_q;
      code_d   = code_q;
      done_d   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               code_d   = code_i;
               pulses_d = code_i;
               cnt_d    = '0;
               if (code_i == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = S_ON;
               end
            end
         end
         S_ON: begin
            if (tick_i) begin
               if (cnt_q == CNT_W'(ON_TICKS - 1)) begin
                  state_d = S_OFF;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_OFF: begin
            if (tick_i) begin
               if (cnt_q == CNT_W'(OFF_TICKS - 1)) begin
                  cnt_d = '0;
                  if (pulses_q > CODE_W'(1)) begin
                     state_d  = S_ON;
                     pulses_d = pulses_q - CODE_W'(1);
                  end else begin
                     state_d = S_GAP;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         S_GAP: begin
            if (tick_i) begin
               if (cnt_q == CNT_W'(GAP_TICKS - 1)) begin
                  cnt_d = '0;
                  if (repeat_i) begin
                     state_d  = S_ON;
                     pulses_d = code_q;
                  end else begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Abort overrides every other transition, including a finishing phase
      if (stop_i) begin
         state_d  = S_IDLE;
         cnt_d    = '0;
         pulses_d = '0;
         done_d   = 1'b0;
      end

      busy_d = (state_d != S_IDLE);
`ifdef BLINK_CODE_DIM_EN
      dim_d  = dim_q + 4'd1;
      led_d  = (state_d == S_ON) && (dim_d < duty_i);
`else
      led_d  = (state_d == S_ON);
`endif
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         pulses_q <= '0;
         code_q   <= '0;
         led_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef BLINK_CODE_DIM_EN
         dim_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         pulses_q <= pulses_d;
         code_q   <= code_d;
         led_q    <= led_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
`ifdef BLINK_CODE_DIM_EN
         dim_q    <= dim_d;
`endif
      end
   end

   assign led_o  = led_q;
   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule

// File: tb/tb_blink_code.sv
// Scoreboard bench for blink_code: the driver queues expected output-change events, a monitor checks them.
module tb_blink_code;

   typedef struct packed {
      logic [2:0]  val;   // {led, busy, done}
      int unsigned len;   // cycles the previous output value lasted; 0 = don't care
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_ni;
   logic       tick_i;
   logic [3:0] code_i;
   logic       code_valid_i;
   logic       code_ready_o;
   logic       repeat_i;
   logic       stop_i;
   logic       led_o;
   logic       busy_o;
   logic       done_o;

   int         n_chk  = 0;
   int         n_fail = 0;
   ev_t        exp_q[$];
   logic [1:0] tcnt = 2'd0;
   logic [2:0] last_m = 3'b000;
   int unsigned acc = 0;
   logic       acc_dc = 1'b0;

`ifdef BLINK_CODE_DIM_EN
   localparam logic MON_LED = 1'b0;
   logic [3:0] duty_i;
   logic [3:0] c_tb;
   always @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) c_tb <= 4'd0;
      else         c_tb <= c_tb + 4'd1;
   end
`else
   localparam logic MON_LED = 1'b1;
`endif

   blink_code dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .tick_i       (tick_i),
      .code_i       (code_i),
      .code_valid_i (code_valid_i),
      .code_ready_o (code_ready_o),
      .repeat_i     (repeat_i),
      .stop_i       (stop_i),
`ifdef BLINK_CODE_DIM_EN
      .duty_i       (duty_i),
`endif
      .led_o        (led_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   always #5 clk = ~clk;

   // Timebase: one-clock tick every 4 clocks
   initial begin
      tick_i = 1'b0;
      forever begin
         @(negedge clk);
         tick_i = (tcnt == 2'd3);
         tcnt   = tcnt + 2'd1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Queue an expected change; with dimming the LED is not tracked, so LED-only changes merge
   task automatic exp_ev(input logic [2:0] val, input int unsigned len);
      logic [2:0] m;
      m = val & {MON_LED, 2'b11};
      if (m == last_m) begin
         acc    = acc + len;
         acc_dc = acc_dc | (len == 0);
      end else begin
         exp_q.push_back('{m, (acc_dc || len == 0) ? 0 : acc + len});
         acc    = 0;
         acc_dc = 1'b0;
         last_m = m;
      end
   endtask

   task automatic nclk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Present a code so it is accepted on a clock that also carries a tick; returns one negedge later
   task automatic send(input logic [3:0] code);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (!tick_i && n < 16);
      if (!tick_i) begin
         n_chk++;
         n_fail++;
         $display("FAIL tick_wait: got no tick expected one within 16 clks");
      end
      nclk(4);
      code_i       = code;
      code_valid_i = 1'b1;
      @(negedge clk);
      code_valid_i = 1'b0;
   endtask

   // Monitor: every change of {led, busy, done} must match the head of the queue
   initial begin
      logic [2:0] prev, cur;
      int cyc, last;
      ev_t e;
      prev = 3'b000;
      cyc  = 0;
      last = 0;
      wait (rst_ni === 1'b1);
      forever begin
         @(negedge clk);
         cyc++;
         cur = {led_o & MON_LED, busy_o, done_o};
         if (cur !== prev) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_event", 32'(cur), 32'(prev));
            end else begin
               e = exp_q.pop_front();
               chk("event_value", 32'(cur), 32'(e.val));
               if (e.len != 0) chk("event_spacing", 32'(cyc - last), e.len);
            end
            prev = cur;
            last = cyc;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected end of test");
      $fatal(1, "timeout");
   end

   initial begin
      rst_ni       = 1'b0;
      code_i       = 4'd0;
      code_valid_i = 1'b0;
      repeat_i     = 1'b0;
      stop_i       = 1'b0;
`ifdef BLINK_CODE_DIM_EN
      duty_i       = 4'd4;
`endif
      nclk(3);
      chk("reset_led",   32'(led_o), 32'd0);
      chk("reset_busy",  32'(busy_o), 32'd0);
      chk("reset_done",  32'(done_o), 32'd0);
      chk("reset_ready", 32'(code_ready_o), 32'd1);
      rst_ni = 1'b1;
      nclk(2);

      // Asynchronous reset in the middle of an ON phase
      exp_ev(3'b110, 0);
      exp_ev(3'b000, 0);
      send(4'd3);
      nclk(2);
      #1 rst_ni = 1'b0;
      #1;
      chk("midrst_led",   32'(led_o), 32'd0);
      chk("midrst_busy",  32'(busy_o), 32'd0);
      chk("midrst_ready", 32'(code_ready_o), 32'd1);
      nclk(2);
      rst_ni = 1'b1;
      nclk(4);

      // code 3: 8 on / 8 off three times, 24-clk gap, done
      exp_ev(3'b110, 0);
      exp_ev(3'b010, 8);  exp_ev(3'b110, 8);
      exp_ev(3'b010, 8);  exp_ev(3'b110, 8);
      exp_ev(3'b010, 8);
      exp_ev(3'b001, 32); exp_ev(3'b000, 1);
      send(4'd3);
      nclk(80);

      // code 0: immediate done, LED and busy never rise
      exp_ev(3'b001, 0);
      exp_ev(3'b000, 1);
      send(4'd0);
      nclk(10);

      // code 2 with repeat; busy-time code_valid/code_i changes have no effect
      repeat_i = 1'b1;
      exp_ev(3'b110, 0);
      exp_ev(3'b010, 8);  exp_ev(3'b110, 8);
      exp_ev(3'b010, 8);  exp_ev(3'b110, 32);
      exp_ev(3'b010, 8);  exp_ev(3'b110, 8);
      exp_ev(3'b010, 8);
      exp_ev(3'b001, 32); exp_ev(3'b000, 1);
      send(4'd2);
      code_i = 4'd7;
      nclk(4);
      code_i = 4'd5;
      code_valid_i = 1'b1;
      chk("busy_ready_1", 32'(code_ready_o), 32'd0);
      nclk(1);
      code_valid_i = 1'b0;
      nclk(55);
      code_valid_i = 1'b1;
      chk("busy_ready_2", 32'(code_ready_o), 32'd0);
      nclk(1);
      code_valid_i = 1'b0;
      nclk(29);
      repeat_i = 1'b0;
      nclk(30);

      // stop on the same clock as the tick that would end ON: abort, no done
      exp_ev(3'b110, 0);
      exp_ev(3'b000, 8);
      send(4'd3);
      nclk(7);
      stop_i = 1'b1;
      nclk(1);
      stop_i = 1'b0;
      nclk(3);

      // stop while idle blocks a handshake
      stop_i       = 1'b1;
      code_valid_i = 1'b1;
      code_i       = 4'd2;
      #1;
      chk("stop_ready", 32'(code_ready_o), 32'd0);
      nclk(1);
      stop_i       = 1'b0;
      code_valid_i = 1'b0;
      nclk(30);

`ifdef BLINK_CODE_DIM_EN
      // duty 4: LED lit only while c < 4 during ON, dark elsewhere
      exp_ev(3'b110, 0);
      exp_ev(3'b010, 8);
      exp_ev(3'b001, 32);
      exp_ev(3'b000, 1);
      send(4'd1);
      for (int i = 0; i < 8; i++) begin
         chk("dim_on", 32'(led_o), 32'(c_tb < 4'd4));
         @(negedge clk);
      end
      for (int i = 0; i < 8; i++) begin
         chk("dim_off", 32'(led_o), 32'd0);
         @(negedge clk);
      end
      nclk(40);
`endif

      nclk(20);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
